pio_poll_sequencer: RTL and testbench

- Avalon-MM master that periodically polls a 4-bit input PIO slave's data register (address 0, registered readdata, fixed read latency 1).
- Detects changes between successive samples and queues change events in a small FIFO.
- Exposes a CPU-side Avalon-MM slave (control, status, event pop, current value) and a level interrupt.
- Sits between the Nios CPU bus and the input PIO, replacing CPU software polling.

---
 rtl/pio_poll_sequencer.sv | 149 ++++++++++++++
 tb/tb_pio_poll_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_poll_sequencer.sv
// Polls a PIO input register over Avalon-MM and queues change events for the CPU.
// CSR slave exposes CTRL, STATUS, EVENT (pop on read) and CURRENT, plus a level irq.
module pio_poll_sequencer #(
  parameter int DATA_W       = 4,
  parameter int POLL_DIV     = 50000,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);

  localparam int CNT_W  = $clog2(POLL_DIV + 1);
  localparam int WAIT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  RELOAD    = CNT_W'(POLL_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
  localparam logic [FCNT_W-1:0] FULL      = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_div;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_read;
  logic                r_primed;
  logic [DATA_W-1:0]   r_current;
  logic                r_enable;
  logic                r_irqEn;
  logic                r_overflow;
  logic                r_irq;
  logic [FCNT_W-1:0]   r_count;
  logic [PTR_W-1:0]    r_rdPtr;
  logic [PTR_W-1:0]    r_wrPtr;
  logic [2*DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [31:0]         r_readdata;

  logic [DATA_W-1:0]   w_sample;
  logic [2*DATA_W-1:0] w_head;
  logic                w_push;
  logic                w_pop;
  logic                w_accept;
  logic                w_unused;

  assign w_sample = m_readdata[DATA_W-1:0];
  assign w_head   = r_mem[r_rdPtr];
  assign w_push   = (r_state == S_CAPTURE) && r_enable && r_primed && (w_sample != r_current);
  assign w_pop    = s_read && (s_address == 2'd2) && (r_count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_accept = w_push && ((r_count != FULL) || w_pop);
  assign w_unused = ^{m_readdata[31:DATA_W], s_writedata[31:9], s_writedata[7:2]};

  assign m_address  = 2'd0;
  assign m_read     = r_read;
  assign s_readdata = r_readdata;
  assign irq        = r_irq;

  // Poll cadence runs off a free-running divider so strobes stay exactly POLL_DIV apart.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_div     <= RELOAD;
      r_wait    <= '0;
      r_read    <= 1'b0;
      r_primed  <= 1'b0;
      r_current <= '0;
    end else begin
      r_read <= 1'b0;
      if (!r_enable || r_div == '0) r_div <= RELOAD;
      else                          r_div <= r_div - CNT_W'(1);
      if (!r_enable) r_primed <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_enable && r_div == '0) begin
            r_state <= S_ISSUE;
            r_read  <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (READ_LATENCY > 1) begin
            r_state <= S_WAIT;
            r_wait  <= WAIT_INIT;
          end else begin
            r_state <= S_CAPTURE;
          end
        end
        S_WAIT: begin
          if (r_wait == '0) r_state <= S_CAPTURE;
          else              r_wait  <= r_wait - WAIT_W'(1);
        end
        S_CAPTURE: begin
          r_current <= w_sample;
          if (r_enable) r_primed <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wrPtr] <= {w_sample ^ r_current, w_sample};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable   <= 1'b0;
      r_irqEn    <= 1'b0;
      r_overflow <= 1'b0;
      r_irq      <= 1'b0;
      r_count    <= '0;
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_readdata <= '0;
    end else begin
      if (s_write && s_address == 2'd0) {r_irqEn, r_enable} <= s_writedata[1:0];
      if (w_pop)    r_rdPtr <= r_rdPtr + PTR_W'(1);
      if (w_accept) r_wrPtr <= r_wrPtr + PTR_W'(1);
      r_count <= r_count + FCNT_W'(w_accept) - FCNT_W'(w_pop);
      // A dropped event in the same cycle as a clear leaves overflow set.
      if (w_push && !w_accept)
        r_overflow <= 1'b1;
      else if (s_write && s_address == 2'd1 && s_writedata[8])
        r_overflow <= 1'b0;
      r_irq <= r_irqEn && ((r_count != '0) || r_overflow);
      r_readdata <= '0;
      if (s_read) begin
        case (s_address)
          2'd0: r_readdata <= {30'd0, r_irqEn, r_enable};
          2'd1: r_readdata <= {22'd0, r_primed, r_overflow, 3'd0, 5'(r_count)};
          2'd2: if (r_count != '0)
                  r_readdata <= {1'b1, 15'd0, 8'(w_head[2*DATA_W-1:DATA_W]), 8'(w_head[DATA_W-1:0])};
          default: r_readdata <= 32'(r_current);
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pio_poll_sequencer.sv
// Randomised scoreboard bench for pio_poll_sequencer: a queue-based model of the event
// FIFO and poll schedule predicts every CSR read, m_read strobe and irq level.
module tb_pio_poll_sequencer;

  localparam int DATA_W       = 4;
  localparam int POLL_DIV     = 8;
  localparam int READ_LATENCY = 1;
  localparam int FIFO_DEPTH   = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        m_address;
  logic              m_read;
  logic [31:0]       m_readdata = '0;
  logic [1:0]        s_address = '0;
  logic              s_read = 1'b0;
  logic              s_write = 1'b0;
  logic [31:0]       s_writedata = '0;
  logic [31:0]       s_readdata;
  logic              irq;
  logic [DATA_W-1:0] inPort = '0;

  int nVectors = 0;
  int nMiscompares = 0;

  always #5 clk = ~clk;

  pio_poll_sequencer #(
    .DATA_W(DATA_W), .POLL_DIV(POLL_DIV), .READ_LATENCY(READ_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m_address(m_address), .m_read(m_read), .m_readdata(m_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
    .s_readdata(s_readdata), .irq(irq)
  );

  // PIO slave with registered readdata; upper bits carry junk the DUT must ignore.
  always @(posedge clk) begin
    if (m_read) m_readdata <= (($urandom() >> DATA_W) << DATA_W) | 32'(inPort);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  bit                mEn, mIrqEn, mOvf, mPrimed, capPending;
  logic [DATA_W-1:0] mCur, capVal;
  logic [31:0]       mQ[$];
  logic [31:0]       expQ[$];
  int                cyc = 0;
  int                c0 = 0;
  bit                expMRead, expIrq;

  always @(posedge clk) begin
    logic [31:0] rsp;
    bit          doPop;
    bit          ovfSet;
    cyc++;
    if (!reset_n) begin
      mEn = 0; mIrqEn = 0; mOvf = 0; mPrimed = 0; capPending = 0;
      mCur = '0; capVal = '0;
      mQ.delete(); expQ.delete();
      expMRead = 0; expIrq = 0;
    end else begin
      expIrq   = mIrqEn && (mQ.size() != 0 || mOvf);
      expMRead = mEn && ((cyc - c0) % POLL_DIV == 0);
      if (s_read) begin
        case (s_address)
          2'd0:    rsp = {30'd0, mIrqEn, mEn};
          2'd1:    rsp = {22'd0, mPrimed, mOvf, 3'd0, 5'(mQ.size())};
          2'd2:    rsp = (mQ.size() != 0) ? mQ[0] : 32'd0;
          default: rsp = 32'(mCur);
        endcase
        expQ.push_back(rsp);
      end
      doPop  = s_read && s_address == 2'd2 && mQ.size() != 0;
      ovfSet = 0;
      if (doPop) void'(mQ.pop_front());
      if (capPending) begin
        if (mEn && mPrimed && capVal != mCur) begin
          if (mQ.size() < FIFO_DEPTH)
            mQ.push_back({1'b1, 15'd0, 8'(capVal ^ mCur), 8'(capVal)});
          else
            ovfSet = 1;
        end
        mCur = capVal;
        if (mEn) mPrimed = 1;
      end
      if (!mEn) mPrimed = 0;
      if (s_write && s_address == 2'd1 && s_writedata[8]) mOvf = 0;
      if (ovfSet) mOvf = 1;
      if (s_write && s_address == 2'd0) begin
        if (!mEn && s_writedata[0]) c0 = cyc;
        mEn    = s_writedata[0];
        mIrqEn = s_writedata[1];
      end
      capPending = m_read;
      capVal     = inPort;
    end
  end

  // Monitor: compares outputs each cycle and pops the scoreboard when read data is due.
  bit rdSeen = 0;
  always @(posedge clk) rdSeen <= reset_n && s_read;

  always @(negedge clk) begin
    if (reset_n) begin
      checkOutput("m_read", 32'(m_read), 32'(expMRead));
      checkOutput("irq", 32'(irq), 32'(expIrq));
      checkOutput("m_address", 32'(m_address), 32'd0);
      if (rdSeen) begin
        if (expQ.size() == 0) begin
          nVectors++;
          nMiscompares++;
          $display("[TB] FAIL csr_read: got 0x%08h, expected no response queued", s_readdata);
        end else begin
          checkOutput("csr_read", s_readdata, expQ.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input bit rd, input bit wr, input logic [1:0] addr, input logic [31:0] data);
    s_read = rd; s_write = wr; s_address = addr; s_writedata = data;
    @(negedge clk);
    s_read = 0; s_write = 0;
  endtask

  task automatic csrRead(input logic [1:0] addr);
    @(negedge clk);
    applyStimulus(1, 0, addr, 32'd0);
  endtask

  task automatic csrWrite(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    applyStimulus(0, 1, addr, data);
  endtask

  task automatic waitStrobe();
    bit ok = 0;
    for (int i = 0; i < 4 * POLL_DIV; i++) begin
      @(negedge clk);
      if (m_read) begin ok = 1; break; end
    end
    if (!ok) begin
      nVectors++;
      nMiscompares++;
      $display("[TB] FAIL strobe_timeout: got no m_read, expected one within %0d cycles", 4 * POLL_DIV);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    $display("[TB] start");
    repeat (3) @(negedge clk);
    reset_n = 1;

    // Idle with polling disabled
    repeat (100) @(negedge clk);
    for (int a = 0; a < 4; a++) csrRead(2'(a));

    // Baseline, equal sample, then 3 -> 5 change
    inPort = 4'h3;
    csrWrite(0, 32'd1);
    waitStrobe();
    waitStrobe();
    @(negedge clk);
    inPort = 4'h5;
    waitStrobe();
    repeat (2) @(negedge clk);
    csrRead(1); csrRead(2); csrRead(1); csrRead(3);

    // Ten changes with no pops overflow the FIFO
    for (int i = 0; i < 10; i++) begin
      inPort = (i % 2 == 0) ? 4'hF : 4'h0;
      waitStrobe();
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    csrRead(1);
    for (int i = 0; i < FIFO_DEPTH + 1; i++) csrRead(2);
    csrWrite(1, 32'h100);
    csrRead(1);

    // irq with a pop landing on the capture edge of a new change
    csrWrite(0, 32'd3);
    inPort = ~inPort;
    waitStrobe();
    repeat (2) @(negedge clk);
    inPort = ~inPort;
    waitStrobe();
    csrRead(2);
    csrRead(1);
    csrRead(2);
    repeat (3) @(negedge clk);

    // Disable while the read is in flight, then re-enable with a changed input
    inPort = ~inPort;
    waitStrobe();
    applyStimulus(0, 1, 2'd0, 32'd0);
    repeat (3) @(negedge clk);
    csrRead(1); csrRead(3);
    inPort = ~inPort;
    csrWrite(0, 32'd1);
    waitStrobe();
    repeat (2) @(negedge clk);
    csrRead(1); csrRead(2);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) inPort = DATA_W'($urandom());
      r = $urandom_range(0, 99);
      if (r < 30)
        applyStimulus(1, 0, 2'($urandom_range(0, 3)), 32'd0);
      else if (r < 33)
        applyStimulus(0, 1, 2'd0, {30'd0, 1'($urandom()), 1'($urandom_range(0, 9) != 0)});
      else if (r < 36)
        applyStimulus(0, 1, 2'd1, 32'h100);
      else if (r < 38)
        applyStimulus(0, 1, 2'($urandom_range(2, 3)), $urandom());
    end

    // Reset asserted while m_read is high
    csrWrite(0, 32'd3);
    waitStrobe();
    #2;
    reset_n = 0;
    #1;
    checkOutput("m_read_async_reset", 32'(m_read), 32'd0);
    checkOutput("irq_async_reset", 32'(irq), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    for (int a = 0; a < 4; a++) csrRead(2'(a));
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
